// File: rtl/dctq_block_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dctq_block_sequencer
// Purpose  : Sequencer for an N x N DCTQ datapath. It accepts pixel blocks
//            through a start/ready handshake. It generates the input write
//            index, the staggered stage counters (DCT row, DCT column,
//            quantiser, output address), the ping-pong bank select, the
//            output valid strobe and the end-of-block pulse. Blocks may be
//            streamed back to back. A drain phase finishes the last block.
//            The sequencer can be stalled with hold or flushed with abort.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1      clock, rising edge
//   reset_n     in   1      asynchronous active-low reset
//   start       in   1      block available; taken when start && ready
//   hold        in   1      stall; freezes all state while high
//   abort       in   1      synchronous flush to IDLE (wins over hold)
//   ready       out  1      a block can be accepted this cycle
//   rnw         out  1      ping-pong bank select, toggles per accepted block
//   cnt1        out  NW     input sample index / RAM write address
//   en_row      out  1      DCT row stage enable
//   row_cnt     out  LOG2N  DCT row-stage counter
//   col_cnt     out  LOG2N  DCT column-stage counter
//   q_cnt       out  NW     quantiser coefficient index
//   addr        out  NW     output coefficient address
//   dctq_valid  out  1      addr / output data valid this cycle
//   block_done  out  1      pulse on the last output sample of a block
// ============================================================================
module dctq_block_sequencer #(
    parameter int LOG2N = 3,
    parameter int OFF_A = 14,
    parameter int OFF_B = 20,
    parameter int OFF_C = 35,
    parameter int OFF_D = 44
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 hold,
    input  logic                 abort,
    output logic                 ready,
    output logic                 rnw,
    output logic [2*LOG2N-1:0]   cnt1,
    output logic                 en_row,
    output logic [LOG2N-1:0]     row_cnt,
    output logic [LOG2N-1:0]     col_cnt,
    output logic [2*LOG2N-1:0]   q_cnt,
    output logic [2*LOG2N-1:0]   addr,
    output logic                 dctq_valid,
    output logic                 block_done
);

    localparam int NW = 2 * LOG2N;
    localparam int B  = 1 << NW;

    localparam logic [NW-1:0] C_OFF_A = NW'(OFF_A);
    localparam logic [NW-1:0] C_OFF_B = NW'(OFF_B);
    localparam logic [NW-1:0] C_OFF_C = NW'(OFF_C);
    localparam logic [NW-1:0] C_OFF_D = NW'(OFF_D);
    localparam logic [NW-1:0] C_LAST  = {NW{1'b1}};

    // Stage offsets must be strictly increasing and leave the last sample
    // of a block free, otherwise the stages would not line up.
    generate
        if (!(OFF_A > 0 && OFF_A < OFF_B && OFF_B < OFF_C && OFF_C < OFF_D &&
              OFF_D <= B - 2)) begin : g_bad_offsets
            $fatal(1, "dctq_block_sequencer: illegal stage offsets");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rnw;
    logic               w_rnw_nxt;
    logic [NW-1:0]      r_cnt1;
    logic [NW-1:0]      w_cnt1_nxt;
    logic               r_en_a;
    logic               r_en_b;
    logic               r_en_c;
    logic               r_en_d;
    logic               w_en_a_nxt;
    logic               w_en_b_nxt;
    logic               w_en_c_nxt;
    logic               w_en_d_nxt;
    logic [LOG2N-1:0]   r_row_cnt;
    logic [LOG2N-1:0]   r_col_cnt;
    logic [NW-1:0]      r_q_cnt;
    logic [NW-1:0]      r_addr;
    logic [LOG2N-1:0]   w_row_nxt;
    logic [LOG2N-1:0]   w_col_nxt;
    logic [NW-1:0]      w_q_nxt;
    logic [NW-1:0]      w_addr_nxt;
    logic               w_accept;
    logic               w_last_in;

    // ------------------------------------------------------------------
    // Handshake. ready depends only on registered state and hold, so it
    // never forms a loop through start.
    // ------------------------------------------------------------------
    assign w_last_in = (r_cnt1 == C_LAST);
    assign ready     = !hold && ((r_state == S_IDLE) ||
                                 ((r_state == S_RUN) && w_last_in));
    assign w_accept  = start && ready;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_rnw     <= 1'b1;
            r_cnt1    <= '0;
            r_en_a    <= 1'b0;
            r_en_b    <= 1'b0;
            r_en_c    <= 1'b0;
            r_en_d    <= 1'b0;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
            r_q_cnt   <= '0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rnw     <= w_rnw_nxt;
            r_cnt1    <= w_cnt1_nxt;
            r_en_a    <= w_en_a_nxt;
            r_en_b    <= w_en_b_nxt;
            r_en_c    <= w_en_c_nxt;
            r_en_d    <= w_en_d_nxt;
            r_row_cnt <= w_row_nxt;
            r_col_cnt <= w_col_nxt;
            r_q_cnt   <= w_q_nxt;
            r_addr    <= w_addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Default is "keep everything", which is exactly
    // the hold behaviour; abort overrides hold.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rnw_nxt   = r_rnw;
        w_cnt1_nxt  = r_cnt1;
        w_en_a_nxt  = r_en_a;
        w_en_b_nxt  = r_en_b;
        w_en_c_nxt  = r_en_c;
        w_en_d_nxt  = r_en_d;
        w_row_nxt   = r_row_cnt;
        w_col_nxt   = r_col_cnt;
        w_q_nxt     = r_q_cnt;
        w_addr_nxt  = r_addr;

        if (abort) begin
            // Flush: bank select keeps its value so the ping-pong pairing
            // of any following block is not disturbed.
            w_state_nxt = S_IDLE;
            w_cnt1_nxt  = '0;
            w_en_a_nxt  = 1'b0;
            w_en_b_nxt  = 1'b0;
            w_en_c_nxt  = 1'b0;
            w_en_d_nxt  = 1'b0;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_q_nxt     = '0;
            w_addr_nxt  = '0;
        end else if (!hold) begin
            // Stage counters free-run once enabled. The counter widths
            // divide B, so they stay aligned to cnt1 across block wraps.
            if (r_en_a) w_row_nxt  = r_row_cnt + 1'b1;
            if (r_en_b) w_col_nxt  = r_col_cnt + 1'b1;
            if (r_en_c) w_q_nxt    = r_q_cnt + 1'b1;
            if (r_en_d) w_addr_nxt = r_addr + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = S_RUN;
                        w_cnt1_nxt  = '0;
                        w_rnw_nxt   = !r_rnw;
                    end
                end

                S_RUN: begin
                    w_cnt1_nxt = r_cnt1 + 1'b1;
                    if (r_cnt1 == C_OFF_A) w_en_a_nxt = 1'b1;
                    if (r_cnt1 == C_OFF_B) w_en_b_nxt = 1'b1;
                    if (r_cnt1 == C_OFF_C) w_en_c_nxt = 1'b1;
                    if (r_cnt1 == C_OFF_D) w_en_d_nxt = 1'b1;
                    if (w_last_in) begin
                        if (w_accept) begin
                            w_rnw_nxt = !r_rnw;
                        end else begin
                            w_state_nxt = S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    w_cnt1_nxt = r_cnt1 + 1'b1;
                    // The output stage produces its last sample when cnt1
                    // reaches OFF_D; after that the pipeline is empty.
                    if (r_cnt1 == C_OFF_D) begin
                        w_state_nxt = S_IDLE;
                        w_cnt1_nxt  = '0;
                        w_en_a_nxt  = 1'b0;
                        w_en_b_nxt  = 1'b0;
                        w_en_c_nxt  = 1'b0;
                        w_en_d_nxt  = 1'b0;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_q_nxt     = '0;
                        w_addr_nxt  = '0;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The valid strobe is masked by hold in the same cycle so
    // a stalled downstream never sees a repeated sample.
    // ------------------------------------------------------------------
    assign rnw        = r_rnw;
    assign cnt1       = r_cnt1;
    assign en_row     = r_en_a;
    assign row_cnt    = r_row_cnt;
    assign col_cnt    = r_col_cnt;
    assign q_cnt      = r_q_cnt;
    assign addr       = r_addr;
    assign dctq_valid = r_en_d && !hold;
    assign block_done = r_en_d && !hold && (r_addr == C_LAST);

endmodule
`default_nettype wire
